esm_instr_buffer: RTL and testbench
===================================

ESM_INSTR_BUFFER -- requirements
Module: esm_instr_buffer

Interface
REQ-001 Parameter Instruction_word_size, default 32, width of one instruction word.
REQ-002 Parameter bs, default 16, number of buffer slots (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; clears all state while low.
REQ-005 in_valid  input  1  producer offers an instruction this cycle.
REQ-006 in_instr  input  Instruction_word_size  instruction offered by the producer.
REQ-007 in_ready  output  1  buffer accepts in_instr this cycle; a write occurs when in_valid & in_ready.
REQ-008 flush  input  1  discard every buffered entry.
REQ-009 issue_valid  input  1  ESM core selects a slot for issue (the core's proceed qualified by valid_count).
REQ-010 issue_index  input  $clog2(bs)  slot selected by the ESM core (its next_buffer_index).
REQ-011 buffer_index  output  $clog2(bs)  slot written in the previous cycle, presented to the core's dependency analyser.
REQ-012 Instr_out  output  Instruction_word_size  instruction written into buffer_index, presented with it.
REQ-013 wr_strobe  output  1  one-cycle pulse; buffer_index/Instr_out are valid this cycle.
REQ-014 valid_entries  output  bs  bit i (MSB-first, [0:bs-1]) = slot i holds an unissued instruction.
REQ-015 issued_instr  output  Instruction_word_size  instruction leaving the buffer.
REQ-016 issued_valid  output  1  one-cycle pulse qualifying issued_instr.
REQ-017 issue_err  output  1  one-cycle pulse: issue_valid targeted an empty slot.
REQ-018 count  output  $clog2(bs)+1  number of set bits in valid_entries.
REQ-019 full, empty  output  1 each  count==bs and count==0 respectively.

Function
REQ-020 Storage: bs x Instruction_word_size slot array plus the valid_entries bitmap; slot contents are not reset and carry no meaning while their valid bit is clear.
REQ-021 Allocation: a write goes to the lowest-numbered slot whose valid bit is clear at the start of the cycle; that bit is set at the clock edge.
REQ-022 in_ready = ~full & ~flush & (state != FLUSH); combinational from registered state and the flush input only.
REQ-023 Presentation: the cycle after a write, wr_strobe=1, buffer_index=allocated slot, Instr_out=written word (1-cycle latency, registered).
REQ-024 Issue: if issue_valid and valid_entries[issue_index]=1, that bit is cleared at the edge; the next cycle issued_valid=1 and issued_instr=slot contents.
REQ-025 If issue_valid targets a clear bit, no state changes, issued_valid stays 0, and issue_err pulses the next cycle.
REQ-026 Simultaneous write and issue in one cycle are both performed; the write never targets the slot being issued that cycle, even if it is the lowest free slot after the clear.
REQ-027 count is updated at the same edge: +1 on write only, -1 on valid issue only, unchanged on both or neither.
REQ-028 FSM states: EMPTY (count==0), ACTIVE (0<count<bs), FULL (count==bs), FLUSH.
REQ-029 Transitions: EMPTY->ACTIVE on write; ACTIVE->FULL when count reaches bs; FULL->ACTIVE on valid issue; ACTIVE->EMPTY when count reaches 0; any state->FLUSH when flush=1.
REQ-030 FLUSH lasts exactly one cycle: valid_entries, count, wr_strobe, issued_valid and issue_err are cleared. The next state is EMPTY, or FLUSH again if flush is still high.
REQ-031 While flush=1, writes and issues presented that cycle are ignored, and no issue_err is raised.
REQ-032 In FULL, in_valid is not accepted, and the producer holds in_instr and in_valid until in_ready.

Reset
REQ-033 While rst=0: state=EMPTY, valid_entries=0, count=0, empty=1, full=0, in_ready=0.
REQ-034 While rst=0: wr_strobe, issued_valid and issue_err are 0, and buffer_index, Instr_out and issued_instr are 0.
REQ-035 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-036 in_ready rises in the first cycle after rst deasserts.

Verification
REQ-037 Fill: bs=16, 16 back-to-back writes of 0x1000+n -> buffer_index 0..15 on consecutive wr_strobe cycles, full=1, in_ready=0, count=16.
REQ-038 Out-of-order issue: fill slots 0-3, issue index 2 -> next cycle issued_instr=0x1002, valid_entries=1101_0000..., and the next write lands in slot 2.
REQ-039 Simultaneous events: full buffer, issue index 5 with in_valid=1 -> write rejected that cycle (in_ready=0). Next cycle, a write lands in slot 5 and count returns to 16.
REQ-040 Bad issue: empty buffer, issue_valid with index 7 -> issue_err pulses for 1 cycle, and count stays 0.
REQ-041 Flush: count=9, flush for 1 cycle with in_valid and issue_valid high -> count=0, empty=1, no issued_valid, no issue_err.
REQ-042 Async reset: assert rst=0 between clock edges with count=5 -> valid_entries=0 and count=0 before the next edge.

Source files
------------

// File: rtl/esm_instr_buffer_if.sv
// rtl/esm_instr_buffer_if.sv - producer/core handshake bundle for the ESM instruction buffer
interface esm_instr_buffer_if #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
);
    localparam int IW = $clog2(bs);

    logic                             in_valid;
    logic [Instruction_word_size-1:0] in_instr;
    logic                             in_ready;
    logic                             flush;
    logic                             issue_valid;
    logic [IW-1:0]                    issue_index;
    logic [IW-1:0]                    buffer_index;
    logic [Instruction_word_size-1:0] Instr_out;
    logic                             wr_strobe;
    logic [0:bs-1]                    valid_entries;
    logic [Instruction_word_size-1:0] issued_instr;
    logic                             issued_valid;
    logic                             issue_err;
    logic [IW:0]                      count;
    logic                             full;
    logic                             empty;

    modport slave (
        input  in_valid, in_instr, flush, issue_valid, issue_index,
        output in_ready, buffer_index, Instr_out, wr_strobe, valid_entries,
               issued_instr, issued_valid, issue_err, count, full, empty
    );

    modport master (
        output in_valid, in_instr, flush, issue_valid, issue_index,
        input  in_ready, buffer_index, Instr_out, wr_strobe, valid_entries,
               issued_instr, issued_valid, issue_err, count, full, empty
    );
endinterface

// File: rtl/esm_instr_buffer.sv
// rtl/esm_instr_buffer.sv - slot buffer feeding the ESM core with out-of-order issue by index
module esm_instr_buffer #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic          clk,
    input  logic          rst,
    esm_instr_buffer_if.slave bus
);
    localparam int IW = $clog2(bs);
    localparam int CW = IW + 1;
    localparam int W  = Instruction_word_size;

    typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic [0:bs-1]   valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [IW-1:0]   buffer_index_q, buffer_index_d;
    logic [W-1:0]    instr_out_q, instr_out_d;
    logic            issued_valid_q, issued_valid_d;
    logic [W-1:0]    issued_instr_q, issued_instr_d;
    logic            issue_err_q, issue_err_d;
    logic [W-1:0]    mem_q [bs];

    logic            full, empty, in_ready;
    logic            blocked, wr_en, iss_hit, iss_ok, iss_bad;
    logic [IW-1:0]   free_idx;

    // run_q keeps in_ready low through reset and releases it one edge later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_EMPTY;
            run_q          <= 1'b0;
            valid_q        <= '0;
            count_q        <= '0;
            wr_strobe_q    <= 1'b0;
            buffer_index_q <= '0;
            instr_out_q    <= '0;
            issued_valid_q <= 1'b0;
            issued_instr_q <= '0;
            issue_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            valid_q        <= valid_d;
            count_q        <= count_d;
            wr_strobe_q    <= wr_strobe_d;
            buffer_index_q <= buffer_index_d;
            instr_out_q    <= instr_out_d;
            issued_valid_q <= issued_valid_d;
            issued_instr_q <= issued_instr_d;
            issue_err_q    <= issue_err_d;
        end
    end

    // Slot contents are don't-care while their valid bit is clear, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[free_idx] <= bus.in_instr;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        full     = (count_q == CW'(bs));
        empty    = (count_q == '0);
        in_ready = run_q & ~full & ~bus.flush & (state_q != S_FLUSH);
    end

    always_comb begin
        blocked = bus.flush | (state_q == S_FLUSH);
        wr_en   = bus.in_valid & in_ready;
        iss_hit = valid_q[bus.issue_index];
        iss_ok  = bus.issue_valid & ~blocked & iss_hit;
        iss_bad = bus.issue_valid & ~blocked & ~iss_hit;
    end

    // The write slot comes from the start-of-cycle bitmap, where an issuing slot is
    // still marked valid, so a same-cycle write can never land on it.
    always_comb begin
        run_d          = 1'b1;
        valid_d        = valid_q;
        count_d        = count_q;
        wr_strobe_d    = 1'b0;
        buffer_index_d = buffer_index_q;
        instr_out_d    = instr_out_q;
        issued_valid_d = 1'b0;
        issued_instr_d = issued_instr_q;
        issue_err_d    = 1'b0;
        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            wr_strobe_d    = wr_en;
            issued_valid_d = iss_ok;
            issue_err_d    = iss_bad;
            if (iss_ok) begin
                valid_d[bus.issue_index] = 1'b0;
                issued_instr_d           = mem_q[bus.issue_index];
            end
            if (wr_en) begin
                valid_d[free_idx] = 1'b1;
                buffer_index_d    = free_idx;
                instr_out_d       = bus.in_instr;
            end
            case ({wr_en, iss_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_EMPTY:  if (wr_en) state_d = S_ACTIVE;
                S_ACTIVE: begin
                    if (count_d == CW'(bs))  state_d = S_FULL;
                    else if (count_d == '0)  state_d = S_EMPTY;
                end
                S_FULL:   if (iss_ok) state_d = S_ACTIVE;
                default:  state_d = S_EMPTY;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = count_q;
    assign bus.valid_entries = valid_q;
    assign bus.wr_strobe     = wr_strobe_q;
    assign bus.buffer_index  = buffer_index_q;
    assign bus.Instr_out     = instr_out_q;
    assign bus.issued_valid  = issued_valid_q;
    assign bus.issued_instr  = issued_instr_q;
    assign bus.issue_err     = issue_err_q;
endmodule

// File: tb/tb_esm_instr_buffer.sv
// tb/tb_esm_instr_buffer.sv - randomized bench against a slot-map reference model
module tb_esm_instr_buffer;
    localparam int BS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    esm_instr_buffer_if #(.Instruction_word_size(32), .bs(BS)) ifc ();

    esm_instr_buffer #(.Instruction_word_size(32), .bs(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // reference model: which slots hold what, plus the outputs expected next cycle
    bit [0:BS-1] m_valid;
    logic [31:0] m_mem [BS];
    bit          m_run, m_flush_st;
    bit          e_wr, e_iv, e_err;
    logic [3:0]  e_idx;
    logic [31:0] e_out, e_iss;
    bit          last_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_free();
        for (int i = 0; i < BS; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = '0; m_run = 0; m_flush_st = 0;
        e_wr = 0; e_iv = 0; e_err = 0; e_idx = '0; e_out = '0; e_iss = '0;
    endtask

    task automatic check_outputs();
        int c;
        c = $countones(m_valid);
        check("wr_strobe", 64'(ifc.wr_strobe), 64'(e_wr));
        if (e_wr) begin
            check("buffer_index", 64'(ifc.buffer_index), 64'(e_idx));
            check("Instr_out", 64'(ifc.Instr_out), 64'(e_out));
        end
        check("issued_valid", 64'(ifc.issued_valid), 64'(e_iv));
        if (e_iv) check("issued_instr", 64'(ifc.issued_instr), 64'(e_iss));
        check("issue_err", 64'(ifc.issue_err), 64'(e_err));
        check("count", 64'(ifc.count), 64'(c));
        check("valid_entries", 64'(ifc.valid_entries), 64'(m_valid));
        check("full", 64'(ifc.full), 64'(c == BS));
        check("empty", 64'(ifc.empty), 64'(c == 0));
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit fl,
                        input bit iv, input logic [3:0] idx);
        bit rdy, blocked, wr, iss, err;
        int fr;
        @(negedge clk);
        check_outputs();
        ifc.in_valid = v; ifc.in_instr = d; ifc.flush = fl;
        ifc.issue_valid = iv; ifc.issue_index = idx;
        #1;
        rdy = m_run && ($countones(m_valid) < BS) && !fl && !m_flush_st;
        check("in_ready", 64'(ifc.in_ready), 64'(rdy));
        blocked = fl || m_flush_st;
        wr  = v && rdy;
        iss = iv && !blocked && m_valid[idx];
        err = iv && !blocked && !m_valid[idx];
        fr  = first_free();
        @(posedge clk);
        last_wr = wr;
        if (fl) begin
            m_valid = '0; e_wr = 0; e_iv = 0; e_err = 0;
        end else begin
            if (iss) begin m_valid[idx] = 0; e_iss = m_mem[idx]; end
            if (wr) begin m_valid[fr] = 1; m_mem[fr] = d; e_idx = 4'(fr); e_out = d; end
            e_wr = wr; e_iv = iss; e_err = err;
        end
        m_flush_st = fl;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 4'h0);
    endtask

    initial begin
        bit          hv;
        logic [31:0] hd;
        bit          fl, iv;
        logic [3:0]  idx;

        ifc.in_valid = 0; ifc.in_instr = '0; ifc.flush = 0;
        ifc.issue_valid = 0; ifc.issue_index = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        check("rst_count", 64'(ifc.count), 64'd0);
        check("rst_empty", 64'(ifc.empty), 64'd1);
        check("rst_full", 64'(ifc.full), 64'd0);
        check("rst_valid", 64'(ifc.valid_entries), 64'd0);
        check("rst_strobes", 64'({ifc.wr_strobe, ifc.issued_valid, ifc.issue_err}), 64'd0);
        check("rst_buffer_index", 64'(ifc.buffer_index), 64'd0);
        check("rst_Instr_out", 64'(ifc.Instr_out), 64'd0);
        check("rst_issued_instr", 64'(ifc.issued_instr), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(ifc.in_ready), 64'd1);
        m_run = 1;

        // fill all slots back to back
        for (int n = 0; n < BS; n++) step(1, 32'h1000 + n, 0, 0, 4'h0);
        idle(); #2;
        check("fill_count", 64'(ifc.count), 64'd16);
        check("fill_full", 64'(ifc.full), 64'd1);
        check("fill_ready", 64'(ifc.in_ready), 64'd0);

        // full buffer: issue slot 5 while offering, write lands there next cycle
        step(1, 32'hABCD_0005, 0, 1, 4'd5);
        step(1, 32'hABCD_0005, 0, 0, 4'd0);
        #2;
        check("refill_idx", 64'(ifc.buffer_index), 64'd5);
        check("refill_count", 64'(ifc.count), 64'd16);

        // out-of-order issue
        step(0, 32'h0, 1, 0, 4'h0);
        idle();
        for (int n = 0; n < 4; n++) step(1, 32'h1000 + n, 0, 0, 4'h0);
        step(0, 32'h0, 0, 1, 4'd2);
        #2;
        check("ooo_issued", 64'(ifc.issued_instr), 64'h1002);
        check("ooo_valid", 64'(ifc.valid_entries), 64'hD000);
        step(1, 32'h2222, 0, 0, 4'h0);
        #2;
        check("ooo_refill_idx", 64'(ifc.buffer_index), 64'd2);

        // bad issue on empty buffer
        step(0, 32'h0, 1, 0, 4'h0);
        idle();
        step(0, 32'h0, 0, 1, 4'd7);
        #2;
        check("bad_err", 64'(ifc.issue_err), 64'd1);
        check("bad_count", 64'(ifc.count), 64'd0);
        idle(); #2;
        check("bad_err_pulse", 64'(ifc.issue_err), 64'd0);

        // flush with traffic presented
        for (int n = 0; n < 9; n++) step(1, 32'h3000 + n, 0, 0, 4'h0);
        step(1, 32'h3333, 1, 1, 4'd3);
        #2;
        check("flush_count", 64'(ifc.count), 64'd0);
        check("flush_empty", 64'(ifc.empty), 64'd1);
        check("flush_iv", 64'(ifc.issued_valid), 64'd0);
        check("flush_err", 64'(ifc.issue_err), 64'd0);
        idle();

        // asynchronous reset between edges
        for (int n = 0; n < 5; n++) step(1, 32'h4000 + n, 0, 0, 4'h0);
        idle();
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(ifc.valid_entries), 64'd0);
        check("arst_count", 64'(ifc.count), 64'd0);
        check("arst_ready", 64'(ifc.in_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("arst_ready_back", 64'(ifc.in_ready), 64'd1);
        m_run = 1;

        // randomized traffic; producer holds a rejected offer
        hv = 0; hd = '0; last_wr = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!(hv && !last_wr)) begin
                hv = ($urandom % 4) != 0;
                hd = $urandom;
            end
            fl  = ($urandom % 40) == 0;
            iv  = ($urandom % 3) == 0;
            idx = 4'($urandom_range(0, BS - 1));
            if (($urandom % 4) != 0 && m_valid != '0) begin
                while (!m_valid[idx]) idx = idx + 4'd1;
            end
            step(hv, hd, fl, iv, idx);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
